// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between fetch and data; data wins unless fetch has been starved.
// Grant is combinational in IDLE, data_ok is combinational from m_data_ok; one transaction in flight.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_addr_ok,
   output logic              i_data_ok,
   output logic [DATA_W-1:0] i_rdata,

   input  logic              d_req,
   input  logic              d_wr,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [3:0]        d_wstrb,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_addr_ok,
   output logic              d_data_ok,
   output logic [DATA_W-1:0] d_rdata,

   output logic              m_req,
   output logic              m_wr,
   output logic [1:0]        m_size,
   output logic [ADDR_W-1:0] m_addr,
   output logic [3:0]        m_wstrb,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              m_addr_ok,
   input  logic              m_data_ok,
   input  logic [DATA_W-1:0] m_rdata,

   output logic              stallreq_if,
   output logic              stallreq_mem,
   output logic              wd_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam int              SC_W   = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIM);
   localparam logic [7:0]      WD_MAX = 8'(TIMEOUT);

   logic [1:0]        r_state;
   logic              r_owner;
   logic              r_m_wr;
   logic [1:0]        r_m_size;
   logic [ADDR_W-1:0] r_m_addr;
   logic [3:0]        r_m_wstrb;
   logic [DATA_W-1:0] r_m_wdata;
   logic [SC_W-1:0]   r_starve_cnt;
   logic [7:0]        r_wd_cnt;
   logic              r_wd_err;

   logic [1:0]        w_state_nxt;
   logic              w_idle;
   logic              w_starved;
   logic              w_grant_d;
   logic              w_grant_i;
   logic              w_req_done;
   logic              w_wait_done;
   logic              w_timeout;
   logic              w_finish;
   logic              w_outstanding;
   logic [DATA_W-1:0] w_rdata;

   // Grants and completions are suppressed while rst is high so an abandoned transaction never pulses.
   assign w_idle        = (r_state == ST_IDLE) && !rst;
   assign w_starved     = i_req && (r_starve_cnt == SC_MAX);
   assign w_grant_d     = w_idle && d_req && !w_starved;
   assign w_grant_i     = w_idle && i_req && !w_grant_d;
   assign w_req_done    = (r_state == ST_REQ) && m_addr_ok && m_data_ok;
   assign w_wait_done   = (r_state == ST_WAIT) && m_data_ok;
   assign w_timeout     = (r_state == ST_WAIT) && !m_data_ok && (r_wd_cnt == WD_MAX);
   assign w_finish      = (w_req_done || w_wait_done || w_timeout) && !rst;
   assign w_outstanding = (r_state != ST_IDLE);
   assign w_rdata       = w_timeout ? '0 : m_rdata;

   assign i_addr_ok = w_grant_i;
   assign d_addr_ok = w_grant_d;
   assign i_data_ok = w_finish && !r_owner;
   assign d_data_ok = w_finish && r_owner;
   assign i_rdata   = w_rdata;
   assign d_rdata   = w_rdata;

   assign m_req   = (r_state == ST_REQ);
   assign m_wr    = r_m_wr;
   assign m_size  = r_m_size;
   assign m_addr  = r_m_addr;
   assign m_wstrb = r_m_wstrb;
   assign m_wdata = r_m_wdata;
   assign wd_err  = r_wd_err;

   assign stallreq_if  = (i_req && !i_addr_ok) || (w_outstanding && !r_owner && !i_data_ok);
   assign stallreq_mem = (d_req && !d_addr_ok) || (w_outstanding &&  r_owner && !d_data_ok);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (w_grant_d || w_grant_i) w_state_nxt = ST_REQ;
         ST_REQ:  if (m_addr_ok) w_state_nxt = m_data_ok ? ST_IDLE : ST_WAIT;
         ST_WAIT: if (m_data_ok || (r_wd_cnt == WD_MAX)) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_owner      <= 1'b0;
         r_m_wr       <= 1'b0;
         r_m_size     <= 2'd0;
         r_m_addr     <= '0;
         r_m_wstrb    <= 4'd0;
         r_m_wdata    <= '0;
         r_starve_cnt <= '0;
         r_wd_cnt     <= 8'd0;
         r_wd_err     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if (w_grant_d) begin
            r_owner   <= 1'b1;
            r_m_wr    <= d_wr;
            r_m_size  <= d_size;
            r_m_addr  <= d_addr;
            r_m_wstrb <= d_wstrb;
            r_m_wdata <= d_wdata;
         end else if (w_grant_i) begin
            r_owner   <= 1'b0;
            r_m_wr    <= 1'b0;
            r_m_size  <= 2'd2;
            r_m_addr  <= i_addr;
            r_m_wstrb <= 4'd0;
            r_m_wdata <= '0;
         end

         // Counts back-to-back data wins that overtook a waiting fetch.
         if (w_grant_d) begin
            if (!i_req)
               r_starve_cnt <= '0;
            else if (r_starve_cnt != SC_MAX)
               r_starve_cnt <= r_starve_cnt + 1'b1;
         end else if (w_grant_i) begin
            r_starve_cnt <= '0;
         end

         if ((r_state == ST_REQ) && m_addr_ok && !m_data_ok)
            r_wd_cnt <= 8'd0;
         else if ((r_state == ST_WAIT) && !m_data_ok && (r_wd_cnt != WD_MAX))
            r_wd_cnt <= r_wd_cnt + 8'd1;

         if (w_timeout)
            r_wd_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic against a transaction-level model.
module tb_mem_port_arbiter;

   localparam int LIM = 4;
   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req = 1'b0;
   logic [31:0] i_addr = '0;
   logic        d_req = 1'b0, d_wr = 1'b0;
   logic [1:0]  d_size = 2'd2;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic [3:0]  d_wstrb = 4'd0;
   logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;
   logic [31:0] m_rdata = '0;

   logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
   logic [31:0] i_rdata, d_rdata;
   logic        m_req, m_wr;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata;
   logic [3:0]  m_wstrb;
   logic        stallreq_if, stallreq_mem, wd_err;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(LIM), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
      .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wstrb(m_wstrb), .m_wdata(m_wdata),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem), .wd_err(wd_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model: the transaction in flight, whether memory has taken its address,
   // and a log of recent grants (1 = data overtook a waiting fetch).
   typedef struct packed {
      logic        dat;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } txn_t;

   txn_t cur;
   bit   pend = 0, acc = 0, sticky_err = 0;
   int   wait_n = 0;
   bit   gq[$];
   bit   e_iok = 0, e_dok = 0;

   function automatic int starve_now();
      int n = 0;
      for (int k = gq.size() - 1; k >= 0; k--) begin
         if (!gq[k]) break;
         n++;
      end
      return (n > LIM) ? LIM : n;
   endfunction

   function automatic bit exp_gd();
      return !pend && d_req && !(i_req && starve_now() == LIM);
   endfunction

   function automatic bit exp_gi();
      return !pend && i_req && !exp_gd();
   endfunction

   function automatic bit exp_tmo();
      return pend && acc && !m_data_ok && (wait_n == TMO);
   endfunction

   function automatic bit exp_fin();
      return (pend && (acc ? m_data_ok : (m_addr_ok && m_data_ok))) || exp_tmo();
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         pend = 0; acc = 0; cur = '0; sticky_err = 0; wait_n = 0;
         gq.delete();
      end else if (!pend) begin
         if (exp_gd()) begin
            cur.dat = 1; cur.wr = d_wr; cur.size = d_size; cur.addr = d_addr;
            cur.wstrb = d_wstrb; cur.wdata = d_wdata;
            pend = 1; acc = 0;
            gq.push_back(i_req);
         end else if (i_req) begin
            cur.dat = 0; cur.wr = 0; cur.size = 2'd2; cur.addr = i_addr;
            cur.wstrb = 4'd0; cur.wdata = '0;
            pend = 1; acc = 0;
            gq.push_back(1'b0);
         end
         if (gq.size() > 8) void'(gq.pop_front());
      end else if (!acc) begin
         if (m_addr_ok) begin
            if (m_data_ok) pend = 0;
            else begin acc = 1; wait_n = 0; end
         end
      end else begin
         if (m_data_ok) pend = 0;
         else if (wait_n == TMO) begin sticky_err = 1; pend = 0; end
         else wait_n++;
      end
   end

   always @(negedge clk) begin
      bit gd, gi, fin, ido, ddo;
      logic [31:0] rd;
      if (rst) begin
         e_iok = 0; e_dok = 0;
      end else begin
         gd  = exp_gd();
         gi  = exp_gi();
         fin = exp_fin();
         ido = fin && !cur.dat;
         ddo = fin && cur.dat;
         rd  = exp_tmo() ? 32'd0 : m_rdata;
         chk("i_addr_ok", i_addr_ok, gi);
         chk("d_addr_ok", d_addr_ok, gd);
         chk("i_data_ok", i_data_ok, ido);
         chk("d_data_ok", d_data_ok, ddo);
         if (ido) chk("i_rdata", i_rdata, rd);
         if (ddo) chk("d_rdata", d_rdata, rd);
         chk("m_req", m_req, pend && !acc);
         if (pend && !acc) begin
            chk("m_addr", m_addr, cur.addr);
            chk("m_wr", m_wr, cur.wr);
            chk("m_size", m_size, cur.size);
            chk("m_wstrb", m_wstrb, cur.wstrb);
            chk("m_wdata", m_wdata, cur.wdata);
         end
         chk("stallreq_if", stallreq_if, (i_req && !gi) || (pend && !cur.dat && !ido));
         chk("stallreq_mem", stallreq_mem, (d_req && !gd) || (pend && cur.dat && !ddo));
         chk("wd_err", wd_err, sticky_err);
         e_iok = gi;
         e_dok = gd;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      i_req = 0; d_req = 0; m_addr_ok = 1; m_data_ok = 1;
      repeat (3) tick();
      m_addr_ok = 0; m_data_ok = 0;
   endtask

   task automatic rand_drive();
      if (!i_req || e_iok) begin
         i_req  = ($urandom_range(99) < 45);
         i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req || e_dok) begin
         d_req   = ($urandom_range(99) < 50);
         d_wr    = $urandom_range(1);
         d_size  = 2'($urandom_range(2));
         d_addr  = $urandom;
         d_wstrb = 4'($urandom_range(15));
         d_wdata = $urandom;
      end
      m_rdata = $urandom;
      if (pend && !acc) begin
         m_addr_ok = ($urandom_range(99) < 50);
         m_data_ok = m_addr_ok ? ($urandom_range(99) < 25) : ($urandom_range(99) < 10);
      end else if (pend) begin
         m_addr_ok = ($urandom_range(99) < 10);
         m_data_ok = ($urandom_range(99) < 40);
      end else begin
         m_addr_ok = ($urandom_range(99) < 10);
         m_data_ok = ($urandom_range(99) < 10);
      end
      rst = ($urandom_range(999) < 3);
   endtask

   byte   got_g[6];
   string exp_g;
   int    ng;
   int    seen;
   logic [31:0] rd_seen;

   initial begin
      repeat (3) tick();
      rst = 0;
      @(negedge clk);
      chk("rst_m_req", m_req, 0);
      chk("rst_m_fields", {m_wr, m_size, m_addr, m_wstrb}, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_pulses", {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}, 0);
      chk("rst_stall", {stallreq_if, stallreq_mem, wd_err}, 0);
      tick();

      // single load with two-cycle read latency
      d_req = 1; d_wr = 0; d_size = 2; d_addr = 32'h100;
      @(negedge clk); chk("t1_grant", d_addr_ok, 1); chk("t1_mreq0", m_req, 0);
      tick(); d_req = 0; m_addr_ok = 1;
      @(negedge clk); chk("t1_mreq1", m_req, 1); chk("t1_stall_a", stallreq_mem, 1);
      tick(); m_addr_ok = 0;
      @(negedge clk); chk("t1_mreq_off", m_req, 0); chk("t1_early", d_data_ok, 0); chk("t1_stall_b", stallreq_mem, 1);
      tick(); m_data_ok = 1; m_rdata = 32'hDEADBEEF;
      @(negedge clk); chk("t1_dok", d_data_ok, 1); chk("t1_rdata", d_rdata, 32'hDEADBEEF); chk("t1_stall_c", stallreq_mem, 0);
      tick(); m_data_ok = 0;

      // store and fetch collide: store goes first
      i_req = 1; i_addr = 32'h400;
      d_req = 1; d_wr = 1; d_wstrb = 4'b0011; d_addr = 32'h104; d_wdata = 32'h1234;
      @(negedge clk); chk("t2_dgrant", d_addr_ok, 1); chk("t2_ihold", i_addr_ok, 0); chk("t2_stall_if_a", stallreq_if, 1);
      tick(); d_req = 0; m_addr_ok = 1; m_data_ok = 1;
      @(negedge clk); chk("t2_mwr", m_wr, 1); chk("t2_wstrb", m_wstrb, 4'b0011); chk("t2_dok", d_data_ok, 1);
      chk("t2_no_igrant", i_addr_ok, 0); chk("t2_stall_if_b", stallreq_if, 1);
      tick(); m_addr_ok = 0; m_data_ok = 0;
      @(negedge clk); chk("t2_igrant", i_addr_ok, 1);
      tick(); i_req = 0; m_addr_ok = 1; m_data_ok = 1;
      @(negedge clk); chk("t2_iaddr", m_addr, 32'h400); chk("t2_isize", m_size, 2); chk("t2_iok", i_data_ok, 1);
      tick(); m_addr_ok = 0; m_data_ok = 0;

      // starvation limiter under continuous contention
      i_req = 1; d_req = 1; d_wr = 0; m_addr_ok = 1; m_data_ok = 1;
      exp_g = "DDDDID";
      for (int k = 0; k < 6; k++) got_g[k] = "-";
      ng = 0;
      for (int c = 0; c < 40 && ng < 6; c++) begin
         @(negedge clk);
         if (d_addr_ok) begin got_g[ng] = "D"; ng++; end
         else if (i_addr_ok) begin got_g[ng] = "I"; ng++; end
         tick();
      end
      for (int k = 0; k < 6; k++) chk($sformatf("t3_grant%0d", k), got_g[k], exp_g[k]);
      drain();

      // memory stalls the address phase for five cycles, with stray data acks
      d_req = 1; d_wr = 0; d_addr = 32'h200;
      @(negedge clk); chk("t4_grant", d_addr_ok, 1);
      tick(); d_req = 0; m_addr_ok = 0; m_data_ok = 1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("t4_mreq%0d", c), m_req, 1);
         chk($sformatf("t4_addr%0d", c), m_addr, 32'h200);
         chk($sformatf("t4_nodok%0d", c), d_data_ok, 0);
         tick();
      end
      m_addr_ok = 1; m_data_ok = 0;
      @(negedge clk); chk("t4_mreq5", m_req, 1); chk("t4_addr5", m_addr, 32'h200);
      tick(); m_addr_ok = 0; m_data_ok = 1;
      @(negedge clk); chk("t4_dok", d_data_ok, 1);
      tick(); m_data_ok = 0;

      // address and data accepted together
      d_req = 1; d_addr = 32'h300;
      @(negedge clk); chk("t5_grant", d_addr_ok, 1);
      tick(); d_req = 0; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h0BADF00D;
      @(negedge clk); chk("t5_dok", d_data_ok, 1); chk("t5_rdata", d_rdata, 32'h0BADF00D);
      tick(); m_addr_ok = 0; m_data_ok = 0; d_req = 1; d_addr = 32'h304;
      @(negedge clk); chk("t5_idle_mreq", m_req, 0); chk("t5_regrant", d_addr_ok, 1);
      tick(); d_req = 0;
      drain();

      // hung memory trips the watchdog
      d_req = 1; d_wr = 0; d_addr = 32'h600;
      @(negedge clk); chk("t6_grant", d_addr_ok, 1);
      tick(); d_req = 0; m_addr_ok = 1;
      tick(); m_addr_ok = 0; m_rdata = 32'hA5A5A5A5;
      seen = 0; rd_seen = '1;
      for (int c = 1; c <= TMO + 20; c++) begin
         @(negedge clk);
         if (d_data_ok) begin seen = c; rd_seen = d_rdata; break; end
         tick();
      end
      chk("t6_wait_cycles", seen, TMO + 1);
      chk("t6_rdata0", rd_seen, 0);
      tick();
      @(negedge clk); chk("t6_wd_err", wd_err, 1); chk("t6_idle", m_req, 0);
      tick();
      @(negedge clk); chk("t6_sticky", wd_err, 1);
      tick();

      // reset while the address phase is pending
      i_req = 1; i_addr = 32'h500;
      @(negedge clk); chk("t7_grant", i_addr_ok, 1);
      tick(); i_req = 0; rst = 1;
      tick(); rst = 0; m_addr_ok = 1; m_data_ok = 1;
      @(negedge clk); chk("t7_mreq", m_req, 0); chk("t7_iok", i_data_ok, 0); chk("t7_wd_clr", wd_err, 0);
      tick();
      @(negedge clk); chk("t7_late_ack", i_data_ok, 0); chk("t7_late_dack", d_data_ok, 0);
      tick(); m_addr_ok = 0; m_data_ok = 0;

      for (int c = 0; c < 2000; c++) begin
         rand_drive();
         tick();
      end
      rst = 0;
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
